// File: rtl/adder_accum_ctrl.sv
// Burst accumulator wrapped around an external combinational N-bit adder.
// Optional macro ACC_SATURATE_EN: on a carry-out, the accumulator saturates to all-ones.
//
// state | meaning
// IDLE  | waiting for start; the operand stream is not accepted
// ACCUM | accepting operands until the remaining count reaches zero
// DONE  | one-cycle done pulse, then back to IDLE
module adder_accum_ctrl #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  input  logic [N-1:0]  add_sum,
  input  logic          add_cout,
  output logic [N-1:0]  acc_out,
  output logic          carry_flag,
  output logic          ovf_flag,
  output logic          zero_flag,
  output logic          neg_flag,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] remaining;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_load;
  logic          handshake;
  logic          ovf_now;

  assign add_a     = acc;
  assign add_b     = in_data;
  assign acc_out   = acc;
  assign zero_flag = (acc == '0);
  assign neg_flag  = acc[N-1];

  assign handshake = (state == ACCUM) && in_valid;
  // Signed overflow: both operands share a sign that the sum does not.
  assign ovf_now   = (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);

`ifdef ACC_SATURATE_EN
  assign acc_load = add_cout ? {N{1'b1}} : add_sum;
`else
  assign acc_load = add_sum;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (remaining == CW'(1))) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      acc        <= '0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        remaining  <= count;
        acc        <= '0;
        carry_flag <= 1'b0;
        ovf_flag   <= 1'b0;
      end else if (handshake) begin
        acc        <= acc_load;
        carry_flag <= carry_flag | add_cout;
        ovf_flag   <= ovf_flag | ovf_now;
        remaining  <= remaining - 1'b1;
      end
    end
  end

endmodule
